// File: rtl/alu_if.sv
// Request/response bundle between a requester and the alu.
//   operand_a, operand_b, operator, op_valid : requester -> alu
//   operation_done, result                   : alu -> requester
interface alu_if;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [7:0]  operator;
    logic        op_valid;
    logic        operation_done;
    logic [31:0] result;

    modport master (
        output operand_a,
        output operand_b,
        output operator,
        output op_valid,
        input  operation_done,
        input  result
    );

    modport slave (
        input  operand_a,
        input  operand_b,
        input  operator,
        input  op_valid,
        output operation_done,
        output result
    );
endinterface

// File: rtl/alu.sv
// 32-bit two-operand ALU with valid/done handshake.
// Single-cycle operators finish one edge after acceptance; MUL runs a
// 32-step shift-add multiplier and finishes 32 edges after acceptance.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : alu_if.slave (operands, operator, op_valid in; done, result out)
module alu (
    input  logic   clock,
    input  logic   reset,
    alu_if.slave   bus
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 8'h00;
    localparam logic [OP_W-1:0] OP_SUB  = 8'h01;
    localparam logic [OP_W-1:0] OP_AND  = 8'h02;
    localparam logic [OP_W-1:0] OP_OR   = 8'h03;
    localparam logic [OP_W-1:0] OP_XOR  = 8'h04;
    localparam logic [OP_W-1:0] OP_SLL  = 8'h05;
    localparam logic [OP_W-1:0] OP_SRL  = 8'h06;
    localparam logic [OP_W-1:0] OP_SRA  = 8'h07;
    localparam logic [OP_W-1:0] OP_SLT  = 8'h08;
    localparam logic [OP_W-1:0] OP_SLTU = 8'h09;
    localparam logic [OP_W-1:0] OP_MUL  = 8'h0A;

    localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_q;        // operand A; multiplicand (shifted left) during MUL
    logic [DATA_W-1:0]   b_q;        // operand B; multiplier (shifted right) during MUL
    logic [OP_W-1:0]     op_q;
    logic                pend;       // a single-cycle op was accepted on the last edge
    logic [DATA_W-1:0]   acc;
    logic [CNT_W-1:0]    count;
    logic                done_q;
    logic [DATA_W-1:0]   result_q;

    logic [DATA_W-1:0]   single_res_c;
    logic [DATA_W-1:0]   mul_step_c;
    logic [SHAMT_W-1:0]  shamt_c;

    assign shamt_c = b_q[SHAMT_W-1:0];

    // Result of the registered single-cycle operation.
    always_comb begin
        single_res_c = '0;
        case (op_q)
            OP_ADD:  single_res_c = DATA_W'(a_q + b_q);
            OP_SUB:  single_res_c = DATA_W'(a_q - b_q);
            OP_AND:  single_res_c = a_q & b_q;
            OP_OR:   single_res_c = a_q | b_q;
            OP_XOR:  single_res_c = a_q ^ b_q;
            OP_SLL:  single_res_c = a_q << shamt_c;
            OP_SRL:  single_res_c = a_q >> shamt_c;
            OP_SRA:  single_res_c = DATA_W'($signed(a_q) >>> shamt_c);
            OP_SLT:  single_res_c = DATA_W'($signed(a_q) < $signed(b_q));
            OP_SLTU: single_res_c = DATA_W'(a_q < b_q);
            default: single_res_c = '0;
        endcase
    end

    // Accumulator value after the current shift-add step.
    assign mul_step_c = DATA_W'(acc + (b_q[0] ? a_q : '0));

    // Control FSM, operand capture, multiplier datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            pend     <= 1'b0;
            acc      <= '0;
            count    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            pend   <= 1'b0;

            // Completion of a single-cycle op captured on the previous edge.
            if (pend) begin
                result_q <= single_res_c;
                done_q   <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        a_q   <= bus.operand_a;
                        b_q   <= bus.operand_b;
                        op_q  <= bus.operator;
                        acc   <= '0;
                        count <= '0;
                        if (bus.operator == OP_MUL) begin
                            state <= MUL_BUSY;
                        end else begin
                            pend <= 1'b1;
                        end
                    end
                end
                MUL_BUSY: begin
                    acc   <= mul_step_c;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    count <= CNT_W'(count + 5'd1);
                    if (count == LAST_STEP) begin
                        result_q <= mul_step_c;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.operation_done = done_q;
    assign bus.result         = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table of single-cycle vectors plus
// hand-written sequences for reset, MUL latency, back-to-back and abort.
module tb_alu;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    alu_if bus ();

    alu dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.operator  = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.op_valid  = 1'b1;
    endtask

    task automatic do_single(input string name, input logic [7:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        drive(op, a, b);
        tick;                                   // acceptance edge
        bus.op_valid  = 1'b0;
        bus.operand_a = 32'hDEAD_BEEF;          // must not affect op in flight
        bus.operand_b = 32'h1234_5678;
        check({name, " no early done"}, 32'(bus.operation_done), 32'h0);
        tick;
        check({name, " done"}, 32'(bus.operation_done), 32'h1);
        check(name, bus.result, exp);
        tick;
        check({name, " done drop"}, 32'(bus.operation_done), 32'h0);
        check({name, " result held"}, bus.result, exp);
    endtask

    initial begin
        int n_done;
        int done_at;
        logic [31:0] mul_res;

        total = 0;
        bad   = 0;

        vecs[0]  = '{"add wrap", 8'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{"sub wrap", 8'h01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[2]  = '{"sra",      8'h07, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[3]  = '{"slt",      8'h08, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[4]  = '{"sltu",     8'h09, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{"and",      8'h02, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
        vecs[6]  = '{"or",       8'h03, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};
        vecs[7]  = '{"xor",      8'h04, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0};
        vecs[8]  = '{"sll 31",   8'h05, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
        vecs[9]  = '{"srl b33",  8'h06, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000};
        vecs[10] = '{"slt pos",  8'h08, 32'h0000_0003, 32'h0000_0007, 32'h0000_0001};
        vecs[11] = '{"bad op",   8'hFF, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000};

        // Reset with op_valid asserted: nothing accepted.
        reset = 1'b1;
        drive(8'h00, 32'h0000_0001, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("reset done", 32'(bus.operation_done), 32'h0);
            check("reset result", bus.result, 32'h0);
        end
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        tick;
        tick;
        check("post reset done", 32'(bus.operation_done), 32'h0);
        check("post reset result", bus.result, 32'h0);

        // Single-cycle vector table.
        for (int i = 0; i < 12; i++) begin
            do_single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Back-to-back with op_valid held for four cycles.
        drive(8'h02, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        tick;
        bus.operator = 8'h03;
        tick;
        check("b2b and done", 32'(bus.operation_done), 32'h1);
        check("b2b and", bus.result, 32'h00F0_000F);
        bus.operator = 8'h04;
        tick;
        check("b2b or done", 32'(bus.operation_done), 32'h1);
        check("b2b or", bus.result, 32'hFFF0_0FFF);
        bus.operator = 8'h55;
        tick;
        check("b2b xor done", 32'(bus.operation_done), 32'h1);
        check("b2b xor", bus.result, 32'hFF00_0FF0);
        bus.op_valid = 1'b0;
        tick;
        check("b2b bad done", 32'(bus.operation_done), 32'h1);
        check("b2b bad", bus.result, 32'h0);
        tick;
        check("b2b done drop", 32'(bus.operation_done), 32'h0);

        // MUL with a stray request pulsed mid-operation.
        drive(8'h0A, 32'h0001_0000, 32'h0001_0003);
        tick;
        bus.op_valid = 1'b0;
        n_done  = 0;
        done_at = 0;
        mul_res = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) drive(8'h00, 32'h0000_0001, 32'h0000_0001);
            if (k == 6) bus.op_valid = 1'b0;
            tick;
            if (bus.operation_done) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = k;
                    mul_res = bus.result;
                end
            end
        end
        check("mul latency", 32'(done_at), 32'd32);
        check("mul done count", 32'(n_done), 32'd1);
        check("mul result", mul_res, 32'h0003_0000);
        check("mul result held", bus.result, 32'h0003_0000);

        // Reset during MUL aborts it without a done pulse.
        drive(8'h0A, 32'h0000_0003, 32'h0000_0005);
        tick;
        bus.op_valid = 1'b0;
        repeat (9) tick;
        reset = 1'b1;
        tick;
        tick;
        reset  = 1'b0;
        n_done = 0;
        check("abort result", bus.result, 32'h0);
        for (int k = 0; k < 30; k++) begin
            tick;
            if (bus.operation_done) n_done++;
        end
        check("abort no done", 32'(n_done), 32'd0);
        check("abort result kept 0", bus.result, 32'h0);
        do_single("add after abort", 8'h00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
